// File: rtl/key_vault_if.sv
// Request/response port between the security controller (master) and key_vault (slave).
// Handshake: a request transfers on a clock edge where req_valid && req_ready; a response
// transfers on an edge where rsp_valid && rsp_ready. A master holds req_* stable while
// req_valid is high and unaccepted; the slave holds rsp_* stable while rsp_valid is high.
interface key_vault_if #(
  parameter int KEY_WIDTH = 256,
  parameter int SLOT_W    = 5,
  parameter int USE_CNT_W = 16
);
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_op;
  logic [SLOT_W-1:0]    req_slot;
  logic [KEY_WIDTH-1:0] req_key;
  logic [USE_CNT_W-1:0] req_limit;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [2:0]           rsp_status;
  logic [KEY_WIDTH-1:0] rsp_key;

  modport master (
    output req_valid, req_op, req_slot, req_key, req_limit, rsp_ready,
    input  req_ready, rsp_valid, rsp_status, rsp_key
  );

  modport slave (
    input  req_valid, req_op, req_slot, req_key, req_limit, rsp_ready,
    output req_ready, rsp_valid, rsp_status, rsp_key
  );
endinterface

// File: rtl/key_vault.sv
// key_vault: slot-based secure key store with per-slot lock and tamper zeroization sweep.
// Optional macro KEY_VAULT_USAGE_LIMIT_EN adds per-slot usage limits and EXPIRED responses.
module key_vault #(
  parameter int KEY_WIDTH = 256,
  parameter int NUM_SLOTS = 32,
  parameter int SLOT_W    = $clog2(NUM_SLOTS),
  parameter int USE_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  key_vault_if.slave           bus,
  input  logic                 secure_en,
  input  logic                 tamper_detect,
  output logic                 zeroize_busy,
  output logic                 tamper_flag,
  output logic [NUM_SLOTS-1:0] slot_valid,
  output logic [1:0]           dbg_state
);

  localparam logic [1:0] OP_STORE   = 2'b00;
  localparam logic [1:0] OP_LOAD    = 2'b01;
  localparam logic [1:0] OP_DESTROY = 2'b10;
  localparam logic [1:0] OP_LOCK    = 2'b11;

  localparam logic [2:0] ST_OK      = 3'd0;
  localparam logic [2:0] ST_EMPTY   = 3'd1;
  localparam logic [2:0] ST_LOCKED  = 3'd2;
  localparam logic [2:0] ST_EXPIRED = 3'd3;
  localparam logic [2:0] ST_DENIED  = 3'd4;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP, S_ZEROIZE} state_e;

  state_e               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [KEY_WIDTH-1:0] key_in_q, key_in_d;
  logic [2:0]           rsp_status_q, rsp_status_d;
  logic [KEY_WIDTH-1:0] rsp_key_q, rsp_key_d;
  logic [SLOT_W-1:0]    zidx_q, zidx_d;
  logic                 tamper_flag_q, tamper_flag_d;

  logic [KEY_WIDTH-1:0] key_q [NUM_SLOTS];
  logic [KEY_WIDTH-1:0] key_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] valid_q, valid_d;
  logic [NUM_SLOTS-1:0] locked_q, locked_d;

`ifdef KEY_VAULT_USAGE_LIMIT_EN
  logic [USE_CNT_W-1:0] limit_in_q, limit_in_d;
  logic [USE_CNT_W-1:0] limit_q [NUM_SLOTS];
  logic [USE_CNT_W-1:0] limit_d [NUM_SLOTS];
  logic [USE_CNT_W-1:0] count_q [NUM_SLOTS];
  logic [USE_CNT_W-1:0] count_d [NUM_SLOTS];
`else
  logic [USE_CNT_W-1:0] unused_req_limit;
  assign unused_req_limit = bus.req_limit;
`endif

  // Every slot register sits on the async reset so a reset wipes key material at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      op_q          <= '0;
      slot_q        <= '0;
      key_in_q      <= '0;
      rsp_status_q  <= '0;
      rsp_key_q     <= '0;
      zidx_q        <= '0;
      tamper_flag_q <= 1'b0;
      key_q         <= '{default: '0};
      valid_q       <= '0;
      locked_q      <= '0;
`ifdef KEY_VAULT_USAGE_LIMIT_EN
      limit_in_q    <= '0;
      limit_q       <= '{default: '0};
      count_q       <= '{default: '0};
`endif
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      slot_q        <= slot_d;
      key_in_q      <= key_in_d;
      rsp_status_q  <= rsp_status_d;
      rsp_key_q     <= rsp_key_d;
      zidx_q        <= zidx_d;
      tamper_flag_q <= tamper_flag_d;
      key_q         <= key_d;
      valid_q       <= valid_d;
      locked_q      <= locked_d;
`ifdef KEY_VAULT_USAGE_LIMIT_EN
      limit_in_q    <= limit_in_d;
      limit_q       <= limit_d;
      count_q       <= count_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    slot_d        = slot_q;
    key_in_d      = key_in_q;
    rsp_status_d  = rsp_status_q;
    rsp_key_d     = rsp_key_q;
    zidx_d        = zidx_q;
    tamper_flag_d = tamper_flag_q;
    key_d         = key_q;
    valid_d       = valid_q;
    locked_d      = locked_q;
`ifdef KEY_VAULT_USAGE_LIMIT_EN
    limit_in_d    = limit_in_q;
    limit_d       = limit_q;
    count_d       = count_q;
`endif

    // Tamper overrides everything: drops any request or response and (re)starts the sweep.
    if (tamper_detect) begin
      state_d       = S_ZEROIZE;
      zidx_d        = '0;
      tamper_flag_d = 1'b1;
      rsp_key_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_d     = bus.req_op;
            slot_d   = bus.req_slot;
            key_in_d = bus.req_key;
`ifdef KEY_VAULT_USAGE_LIMIT_EN
            limit_in_d = bus.req_limit;
`endif
            state_d  = S_EXEC;
          end
        end

        S_EXEC: begin
          state_d      = S_RESP;
          rsp_key_d    = '0;
          rsp_status_d = ST_OK;
          if (!secure_en) begin
            rsp_status_d = ST_DENIED;
          end else begin
            case (op_q)
              OP_STORE: begin
                if (locked_q[slot_q]) begin
                  rsp_status_d = ST_LOCKED;
                end else begin
                  key_d[slot_q]   = key_in_q;
                  valid_d[slot_q] = 1'b1;
`ifdef KEY_VAULT_USAGE_LIMIT_EN
                  limit_d[slot_q] = limit_in_q;
                  count_d[slot_q] = '0;
`endif
                end
              end
              OP_LOAD: begin
                if (!valid_q[slot_q]) begin
                  rsp_status_d = ST_EMPTY;
`ifdef KEY_VAULT_USAGE_LIMIT_EN
                end else if (limit_q[slot_q] != '0 && count_q[slot_q] == limit_q[slot_q]) begin
                  rsp_status_d = ST_EXPIRED;
                end else begin
                  rsp_key_d = key_q[slot_q];
                  if (count_q[slot_q] != {USE_CNT_W{1'b1}}) begin
                    count_d[slot_q] = count_q[slot_q] + USE_CNT_W'(1);
                  end
                end
`else
                end else begin
                  rsp_key_d = key_q[slot_q];
                end
`endif
              end
              OP_DESTROY: begin
                if (locked_q[slot_q]) begin
                  rsp_status_d = ST_LOCKED;
                end else begin
                  key_d[slot_q]   = '0;
                  valid_d[slot_q] = 1'b0;
`ifdef KEY_VAULT_USAGE_LIMIT_EN
                  limit_d[slot_q] = '0;
                  count_d[slot_q] = '0;
`endif
                end
              end
              default: begin
                if (!valid_q[slot_q]) begin
                  rsp_status_d = ST_EMPTY;
                end else begin
                  locked_d[slot_q] = 1'b1;
                end
              end
            endcase
          end
        end

        S_RESP: begin
          if (bus.rsp_ready) begin
            state_d   = S_IDLE;
            rsp_key_d = '0;
          end
        end

        default: begin
          key_d[zidx_q]    = '0;
          valid_d[zidx_q]  = 1'b0;
          locked_d[zidx_q] = 1'b0;
`ifdef KEY_VAULT_USAGE_LIMIT_EN
          limit_d[zidx_q]  = '0;
          count_d[zidx_q]  = '0;
`endif
          if (zidx_q == LAST_SLOT) begin
            state_d = S_IDLE;
          end else begin
            zidx_d = zidx_q + SLOT_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.rsp_valid  = (state_q == S_RESP);
  assign bus.rsp_status = rsp_status_q;
  assign bus.rsp_key    = rsp_key_q;
  assign zeroize_busy   = (state_q == S_ZEROIZE);
  assign tamper_flag    = tamper_flag_q;
  assign slot_valid     = valid_q;
  assign dbg_state      = state_q;

endmodule
